irq_ctrl: RTL and testbench

- Three-source prioritised, nesting interrupt controller that sequences the CPU core's interrupt entry and exit.
- Converts the pushbutton request lines (pro_reset[2:0] in the top-level bench) into level-held pending requests.
- Decides which request may preempt the current service level, presents a 12-bit entry address to the PC mux, and tracks in-service levels until the CPU executes ERET.

---
 rtl/irq_pkg.sv | 35 +++
 rtl/irq_edge_det.sv | 41 ++++
 rtl/irq_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the three-source nesting interrupt controller.
package irq_pkg;
  localparam int NUM_SRC = 3;
  localparam int VEC_W   = 12;
  localparam int IDX_W   = 2;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Highest set bit wins; bit NUM_SRC-1 is the top priority.
  function automatic prio_t prio_enc(input logic [NUM_SRC-1:0] req);
    prio_t r;
    r.vld = 1'b0;
    r.idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        r.vld = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                input logic [VEC_W-1:0] stride,
                                                input logic [IDX_W-1:0] idx);
    logic [VEC_W-1:0] off;
    off = VEC_W'(idx) * stride;
    return base + off;
  endfunction
endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector on the raw request lines; one-cycle pulse per 0->1 transition.
// IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the detector (+2 cycles latency).
module irq_edge_det
  import irq_pkg::*;
#(
  parameter int W = NUM_SRC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_rise
);
  logic [W-1:0] w_lvl;
  logic [W-1:0] r_prev;

`ifdef IRQ_SYNC_EN
  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = r_sync2;
`else
  assign w_lvl = i_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= '0;
    else     r_prev <= w_lvl;
  end

  assign o_rise = w_lvl & ~r_prev;
endmodule

// File: rtl/irq_ctrl.sv
// Prioritised nesting interrupt controller: latches request edges, arbitrates against the
// current service level, and tracks in-service sources until ERET. IRQ_SYNC_EN adds input sync.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_BASE   = 12'h000,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 12'h010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               int_en,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [IDX_W-1:0]   cur_level
);
  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_sel, w_sel_nxt;
  logic               r_int_req, w_int_req_nxt;
  logic [VEC_W-1:0]   r_int_vec, w_int_vec_nxt;
  logic [NUM_SRC-1:0] r_pending, w_pending_nxt;
  logic [NUM_SRC-1:0] r_in_service, w_in_service_nxt;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_above;
  logic [NUM_SRC-1:0] w_elig;
  prio_t              w_cand;
  prio_t              w_top_isv;
  logic [IDX_W-1:0]   w_cur_level;

  irq_edge_det #(.W(NUM_SRC)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_in   (irq_in),
    .o_rise (w_rise)
  );

  assign w_top_isv   = prio_enc(r_in_service);
  assign w_cur_level = w_top_isv.vld ? (w_top_isv.idx + 2'd1) : 2'd0;

  // Only sources strictly above the level being serviced may preempt it.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_above[i] = (IDX_W'(i) >= w_cur_level);
    end
  end

  assign w_elig = r_pending & irq_mask & w_above;
  assign w_cand = prio_enc(w_elig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_int_req    <= 1'b0;
      r_int_vec    <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_int_req    <= w_int_req_nxt;
      r_int_vec    <= w_int_vec_nxt;
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_int_req_nxt    = r_int_req;
    w_int_vec_nxt    = r_int_vec;
    w_pending_nxt    = r_pending;
    w_in_service_nxt = r_in_service;

    // ERET retires the innermost level before any same-cycle ack marks a new one.
    if (eret && w_top_isv.vld) begin
      w_in_service_nxt[w_top_isv.idx] = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (int_en && w_cand.vld) begin
          w_state_nxt   = REQ;
          w_int_req_nxt = 1'b1;
          w_sel_nxt     = w_cand.idx;
          w_int_vec_nxt = vec_addr(VEC_BASE, VEC_STRIDE, w_cand.idx);
        end
      end
      REQ: begin
        if (int_ack) begin
          w_pending_nxt[r_sel]    = 1'b0;
          w_in_service_nxt[r_sel] = 1'b1;
          w_int_req_nxt           = 1'b0;
          w_state_nxt             = IDLE;
        end else if (!int_en || !w_cand.vld) begin
          w_int_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_sel_nxt     = w_cand.idx;
          w_int_vec_nxt = vec_addr(VEC_BASE, VEC_STRIDE, w_cand.idx);
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_int_req_nxt = 1'b0;
      end
    endcase

    // A fresh edge wins over the ack clear of the same source.
    w_pending_nxt = w_pending_nxt | w_rise;
  end

  assign int_req    = r_int_req;
  assign int_vec    = r_int_vec;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign cur_level  = w_cur_level;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, corner sequences, random vs model.
module tb_irq_ctrl;
  import irq_pkg::*;

`ifdef IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int TB_BASE   = 0;
  localparam int TB_STRIDE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = 3'b000;
  logic [2:0]  irq_mask = 3'b000;
  logic        int_en = 1'b0;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [11:0] int_vec;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [1:0]  cur_level;

  int checks = 0;
  int errors = 0;

  irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .int_en     (int_en),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service),
    .cur_level  (cur_level)
  );

  always #5 clk = ~clk;

  // Reference model: state as plain bit sets, history of irq_in as a queue.
  bit [2:0]    m_hist[$];
  bit [2:0]    m_pend;
  bit [2:0]    m_isv;
  bit          m_req;
  int          m_sel;
  logic [11:0] m_vec;

  function automatic void model_reset();
    m_pend = 3'b000;
    m_isv  = 3'b000;
    m_req  = 1'b0;
    m_sel  = 0;
    m_vec  = 12'h000;
    m_hist.delete();
    for (int k = 0; k < SYNC + 1; k++) m_hist.push_back(3'b000);
  endfunction

  function automatic int m_level();
    for (int i = 2; i >= 0; i--) if (m_isv[i]) return i + 1;
    return 0;
  endfunction

  function automatic void model_step();
    bit [2:0] seen, prev, np, ni;
    int lvl, cand;
    m_hist.push_front(irq_in);
    seen = m_hist[SYNC];
    prev = m_hist[SYNC + 1];
    void'(m_hist.pop_back());
    lvl  = m_level();
    cand = -1;
    for (int i = 0; i < 3; i++) if (m_pend[i] && irq_mask[i] && (i + 1 > lvl)) cand = i;
    np = m_pend;
    ni = m_isv;
    if (eret) begin
      for (int i = 2; i >= 0; i--) begin
        if (ni[i]) begin
          ni[i] = 1'b0;
          break;
        end
      end
    end
    if (m_req) begin
      if (int_ack) begin
        np[m_sel] = 1'b0;
        ni[m_sel] = 1'b1;
        m_req     = 1'b0;
      end else if (!int_en || cand < 0) begin
        m_req = 1'b0;
      end else begin
        m_sel = cand;
        m_vec = 12'((TB_BASE + cand * TB_STRIDE) % 4096);
      end
    end else if (int_en && cand >= 0) begin
      m_req = 1'b1;
      m_sel = cand;
      m_vec = 12'((TB_BASE + cand * TB_STRIDE) % 4096);
    end
    np     = np | (seen & ~prev);
    m_pend = np;
    m_isv  = ni;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, int_req, int_vec, pending, in_service, cur_level};
  endfunction

  // Called at a negedge: drive inputs, let one rising edge pass, compare at the next negedge.
  task automatic step(input logic [2:0] irq, input logic [2:0] msk, input logic en,
                      input logic ack, input logic er);
    irq_in   = irq;
    irq_mask = msk;
    int_en   = en;
    int_ack  = ack;
    eret     = er;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", outs(), {11'd0, m_req, m_vec, m_pend, m_isv, 2'(m_level())});
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk(name, outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  irq;
    logic [2:0]  msk;
    logic        en;
    logic        ack;
    logic        er;
    logic        req;
    logic [11:0] vec;
    logic [2:0]  pend;
    logic [2:0]  isv;
    logic [1:0]  lvl;
  } row_t;

  row_t tbl[30];

  logic [2:0] r_irq;
  logic [2:0] r_msk;
  logic       r_en, r_ack, r_er, a;
  int         acks, psets;
  logic       last_p1;

  initial begin
    //          irq     msk     en    ack   er    req   vec      pend    isv     lvl
    tbl[0]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 3'b000, 2'd0};
    tbl[1]  = '{3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3'b001, 3'b000, 2'd0};
    tbl[2]  = '{3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 3'b001, 3'b000, 2'd0};
    tbl[3]  = '{3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 3'b000, 3'b001, 2'd1};
    tbl[4]  = '{3'b100, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3'b100, 3'b001, 2'd1};
    tbl[5]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 3'b100, 3'b001, 2'd1};
    tbl[6]  = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 12'h020, 3'b000, 3'b101, 2'd3};
    tbl[7]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 3'b000, 3'b001, 2'd1};
    tbl[8]  = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 3'b000, 3'b000, 2'd0};
    tbl[9]  = '{3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 3'b010, 3'b000, 2'd0};
    tbl[10] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 3'b010, 3'b000, 2'd0};
    tbl[11] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 3'b000, 3'b010, 2'd2};
    tbl[12] = '{3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 3'b001, 3'b010, 2'd2};
    tbl[13] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 3'b001, 3'b010, 2'd2};
    tbl[14] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 12'h010, 3'b001, 3'b000, 2'd0};
    tbl[15] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 3'b001, 3'b000, 2'd0};
    tbl[16] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 3'b000, 3'b001, 2'd1};
    tbl[17] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 3'b000, 3'b000, 2'd0};
    tbl[18] = '{3'b011, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3'b011, 3'b000, 2'd0};
    tbl[19] = '{3'b000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 12'h010, 3'b011, 3'b000, 2'd0};
    tbl[20] = '{3'b000, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 3'b001, 3'b010, 2'd2};
    tbl[21] = '{3'b000, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 12'h010, 3'b001, 3'b000, 2'd0};
    tbl[22] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 3'b001, 3'b000, 2'd0};
    tbl[23] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 3'b000, 3'b001, 2'd1};
    tbl[24] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 3'b000, 3'b000, 2'd0};
    tbl[25] = '{3'b100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b100, 3'b000, 2'd0};
    tbl[26] = '{3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b100, 3'b000, 2'd0};
    tbl[27] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 3'b100, 3'b000, 2'd0};
    tbl[28] = '{3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 3'b100, 3'b000, 2'd0};
    tbl[29] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 3'b100, 3'b000, 2'd0};

    @(negedge clk);
    chk("reset_state", outs(), 32'd0);
    model_reset();
    rst = 1'b0;

`ifndef IRQ_SYNC_EN
    for (int r = 0; r < 30; r++) begin
      step(tbl[r].irq, tbl[r].msk, tbl[r].en, tbl[r].ack, tbl[r].er);
      chk($sformatf("row%0d", r), outs(),
          {11'd0, tbl[r].req, tbl[r].vec, tbl[r].pend, tbl[r].isv, tbl[r].lvl});
    end
`endif

    // Reset while a request is outstanding.
    step(3'b100, 3'b111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("req_before_rst", {31'd0, int_req}, 32'd1);
    async_reset("rst_mid_req");

    // A held level produces a single pending set and a single ack.
    acks    = 0;
    psets   = 0;
    last_p1 = pending[1];
    for (int c = 0; c < 20; c++) begin
      a = int_req;
      step(3'b010, 3'b111, 1'b1, a, 1'b0);
      if (a) acks++;
      if (pending[1] && !last_p1) psets++;
      last_p1 = pending[1];
    end
    chk("held_acks", acks, 1);
    chk("held_psets", psets, 1);

    // Edge on source 1 coinciding with its ack keeps it pending.
    step(3'b000, 3'b111, 1'b1, 1'b0, 1'b1);
    step(3'b010, 3'b111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < SYNC + 1; c++) step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("coin_req", {19'd0, int_req, int_vec}, {19'd0, 1'b1, 12'h010});
    step(3'b010, 3'b111, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < SYNC; c++) step(3'b010, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("coin_pend", {29'd0, pending}, 32'd2);
    chk("coin_isv", {29'd0, in_service}, 32'd2);
    step(3'b000, 3'b111, 1'b1, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r_irq = irq_in;
      for (int b = 0; b < 3; b++) if ($urandom_range(7) == 0) r_irq[b] = ~r_irq[b];
      r_msk = ($urandom_range(15) == 0) ? 3'($urandom_range(7)) : irq_mask;
      r_en  = ($urandom_range(9) != 0);
      r_ack = int_req ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
      r_er  = ($urandom_range(7) == 0);
      step(r_irq, r_msk, r_en, r_ack, r_er);
      if (c % 700 == 350) async_reset("rst_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
